// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: pipeline and MDU requests in, register-file
// write port, stall request and busy scoreboard out.
interface wb_arbiter_if;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic [31:0] pipe_pc;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic [31:0] mdu_pc;
   logic        grf_we;
   logic [4:0]  grf_addr;
   logic [31:0] grf_wdata;
   logic [31:0] grf_pc;
   logic        stall_req;
   logic [31:0] busy_mask;

   modport slave (
      input  pipe_we, pipe_addr, pipe_data, pipe_pc,
      input  mdu_valid, mdu_addr, mdu_data, mdu_pc,
      output mdu_ready,
      output grf_we, grf_addr, grf_wdata, grf_pc,
      output stall_req, busy_mask
   );

   modport master (
      output pipe_we, pipe_addr, pipe_data, pipe_pc,
      output mdu_valid, mdu_addr, mdu_data, mdu_pc,
      input  mdu_ready,
      input  grf_we, grf_addr, grf_wdata, grf_pc,
      input  stall_req, busy_mask
   );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: pipeline wins, MDU results buffered.
// Optional write trace enabled by defining WB_ARBITER_TRACE_EN.
module wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int FIFO_DEPTH   = 2
) (
   input logic         clk,
   input logic         reset,
   wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;

   ent_t            r_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_vld;
   logic [PW-1:0]   r_rd;
   logic [PW-1:0]   r_wr;
   logic [PW:0]     r_cnt;
   logic [3:0]      r_wait;
   logic            r_stall;
   logic            r_grf_we;
   logic [4:0]      r_grf_addr;
   logic [31:0]     r_grf_wdata;
   logic [31:0]     r_grf_pc;

   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic [3:0]      w_wait_nxt;
   logic            w_sel_we;
   ent_t            w_sel;
   logic [31:0]     w_busy;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == (PW+1)'(FIFO_DEPTH));
   assign w_push  = bus.mdu_valid & ~w_full;
   assign w_pop   = ~bus.pipe_we & ~w_empty;

   assign bus.mdu_ready = ~w_full;
   assign bus.grf_we    = r_grf_we;
   assign bus.grf_addr  = r_grf_addr;
   assign bus.grf_wdata = r_grf_wdata;
   assign bus.grf_pc    = r_grf_pc;
   assign bus.stall_req = r_stall;
   assign bus.busy_mask = w_busy;

   // Head is read from registered state only, so a push never bypasses.
   always_comb begin
      w_sel_we = 1'b0;
      w_sel    = '0;
      unique case (1'b1)
         bus.pipe_we: begin
            w_sel_we = 1'b1;
            w_sel    = '{bus.pipe_addr, bus.pipe_data,
                         bus.pipe_pc};
         end
         w_pop: begin
            w_sel_we = 1'b1;
            w_sel    = r_mem[r_rd];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_wait_nxt = r_wait;
      if (w_empty || w_pop)
         w_wait_nxt = 4'd0;
      else if (r_wait != 4'hF)
         w_wait_nxt = r_wait + 4'd1;
   end

   always_comb begin
      w_busy = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (r_vld[i] && r_mem[i].addr != 5'd0)
            w_busy[r_mem[i].addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= '{bus.mdu_addr, bus.mdu_data,
                          bus.mdu_pc};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rd] <= 1'b0;
            r_rd        <= r_rd + PW'(1);
         end
         if (w_push) begin
            r_vld[r_wr] <= 1'b1;
            r_wr        <= r_wr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait  <= 4'd0;
         r_stall <= 1'b0;
      end else begin
         r_wait  <= w_wait_nxt;
         r_stall <= (32'(w_wait_nxt) >= STARVE_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grf_we    <= 1'b0;
         r_grf_addr  <= '0;
         r_grf_wdata <= '0;
         r_grf_pc    <= '0;
      end else begin
         r_grf_we <= w_sel_we;
         if (w_sel_we) begin
            r_grf_addr  <= w_sel.addr;
            r_grf_wdata <= (w_sel.addr == 5'd0) ?
                           32'h0 : w_sel.data;
            r_grf_pc    <= w_sel.pc;
         end
      end
   end

`ifdef WB_ARBITER_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && r_grf_we)
         $display("@%08h: $%0d <= %08h", r_grf_pc,
                  r_grf_addr, r_grf_wdata);
   end
`endif
endmodule
